// File: rtl/apb_gpio_debounce_if.sv
// APB bus bundle for the GPIO/debounce peripheral.
// The master drives the request side; the slave returns read data and status.
interface apb_gpio_debounce_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_debounce.sv
// APB GPIO with per-channel synchroniser, debounce filter and edge/level interrupts.
// Zero-wait-state slave; interrupt status is write-1-to-clear with set priority.
module apb_gpio_debounce #(
  parameter int IO_NUM      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8,
  parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_RST = '0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_gpio_debounce_if.slave  apb,
  input  logic [IO_NUM-1:0]   GPIO_IN,
  output logic [IO_NUM-1:0]   GPIO_OUT,
  output logic [IO_NUM-1:0]   GPIO_OE,
  output logic [IO_NUM-1:0]   INT,
  output logic                INT_OR
);

  localparam int TW = 2 * IO_NUM;

  logic [IO_NUM-1:0]     out_reg;
  logic [IO_NUM-1:0]     oe_reg;
  logic [IO_NUM-1:0]     int_en_reg;
  logic [IO_NUM-1:0]     int_stat_reg;
  logic [IO_NUM-1:0]     int_stat_next;
  logic                  int_or_reg;
  logic [TW-1:0]         type_reg;
  logic [DEBOUNCE_W-1:0] deb_reg;

  logic [IO_NUM-1:0]     d_vec;
  logic [IO_NUM-1:0]     d_prev_reg;
  logic [IO_NUM-1:0]     event_reg;
  logic [IO_NUM-1:0]     event_next;

  logic [5:0]            widx;
  logic                  mapped;
  logic                  wr_en;
  logic [IO_NUM-1:0]     wdata_io;
  logic [IO_NUM-1:0]     w1c;
  logic [63:0]           type_ext;
  logic [63:0]           type_wr;
  logic [31:0]           rdata;
  logic [DEBOUNCE_W:0]   thr;
  logic                  unused;

  assign widx     = apb.PADDR[7:2];
  assign mapped   = (widx <= 6'd9);
  assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wdata_io = apb.PWDATA[IO_NUM-1:0];
  assign type_ext = 64'(type_reg);
  assign unused   = &{1'b0, apb.PADDR[1:0]};

  // A threshold of 0 behaves like 1 so the filter never stalls.
  assign thr = (deb_reg == '0) ? (DEBOUNCE_W+1)'(1) : {1'b0, deb_reg};

  always_comb begin
    type_wr = type_ext;
    if (widx == 6'd4) type_wr[31:0]  = apb.PWDATA;
    if (widx == 6'd5) type_wr[63:32] = apb.PWDATA;
  end

  always_comb begin
    rdata = '0;
    case (widx)
      6'd0: rdata = 32'(d_vec);
      6'd1: rdata = 32'(out_reg);
      6'd2: rdata = 32'(oe_reg);
      6'd3: rdata = 32'(int_en_reg);
      6'd4: rdata = type_ext[31:0];
      6'd5: rdata = type_ext[63:32];
      6'd6: rdata = 32'(int_stat_reg);
      6'd7: rdata = 32'(deb_reg);
      default: rdata = '0;
    endcase
  end

  assign apb.PRDATA  = apb.PSEL ? rdata : '0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      out_reg    <= '0;
      oe_reg     <= '0;
      int_en_reg <= '0;
      type_reg   <= '0;
      deb_reg    <= DEBOUNCE_RST;
    end else if (wr_en) begin
      case (widx)
        6'd1: out_reg    <= wdata_io;
        6'd2: oe_reg     <= wdata_io;
        6'd3: int_en_reg <= wdata_io;
        6'd4, 6'd5: type_reg <= type_wr[TW-1:0];
        6'd7: deb_reg    <= apb.PWDATA[DEBOUNCE_W-1:0];
        6'd8: out_reg    <= out_reg | wdata_io;
        6'd9: out_reg    <= out_reg & ~wdata_io;
        default: ;
      endcase
    end
  end

  // New events take priority over a simultaneous write-1-to-clear.
  assign w1c           = (wr_en && widx == 6'd6) ? wdata_io : '0;
  assign int_stat_next = (int_stat_reg & ~w1c) | (event_reg & int_en_reg);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      int_stat_reg <= '0;
      int_or_reg   <= 1'b0;
      d_prev_reg   <= '0;
      event_reg    <= '0;
    end else begin
      int_stat_reg <= int_stat_next;
      int_or_reg   <= |int_stat_next;
      d_prev_reg   <= d_vec;
      event_reg    <= event_next;
    end
  end

  generate
    for (genvar gi = 0; gi < IO_NUM; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [DEBOUNCE_W-1:0]  cnt_reg;
      logic [DEBOUNCE_W:0]    cnt_inc;
      logic                   d_reg;
      logic                   s;
      logic                   ev;

      assign s       = sync_reg[SYNC_STAGES-1];
      assign cnt_inc = {1'b0, cnt_reg} + (DEBOUNCE_W+1)'(1);

      always_ff @(posedge PCLK) begin
        if (PRESET) begin
          sync_reg <= '0;
          cnt_reg  <= '0;
          d_reg    <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], GPIO_IN[gi]};
          if (s == d_reg) begin
            cnt_reg <= '0;
          end else if (cnt_inc >= thr) begin
            d_reg   <= s;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_inc[DEBOUNCE_W-1:0];
          end
        end
      end

      always_comb begin
        ev = 1'b0;
        case (type_reg[2*gi +: 2])
          2'b00: ev = d_reg & ~d_prev_reg[gi];
          2'b01: ev = ~d_reg & d_prev_reg[gi];
          2'b10: ev = d_reg ^ d_prev_reg[gi];
          2'b11: ev = d_reg;
          default: ev = 1'b0;
        endcase
      end

      assign d_vec[gi]      = d_reg;
      assign event_next[gi] = ev;
    end
  endgenerate

  assign GPIO_OUT = out_reg;
  assign GPIO_OE  = oe_reg;
  assign INT      = int_stat_reg;
  assign INT_OR   = int_or_reg;

endmodule

// File: doc/apb_gpio_debounce.md
# apb_gpio_debounce

APB-attached general-purpose I/O block with 1–32 channels: per-channel output/enable registers, synchronised and debounced inputs, and per-channel configurable edge/level interrupts with write-1-to-clear status. It is the parametrised successor to the existing GPIO core. It adds debounce filtering, selectable interrupt mode per channel at run time, atomic set/clear of outputs, and error response on unmapped addresses. It sits on the peripheral APB bus beside the other APB slaves and is exercised by the APB master BFM in the user testbench.

## Interface
- IO_NUM, 8, number of channels (1–32); register bits at or above IO_NUM read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (2–3)
- DEBOUNCE_W, 8, width of the debounce threshold and of each per-channel counter
- DEBOUNCE_RST, 0, reset value of the DEBOUNCE register

- PCLK  in  1  sole clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  8  byte address; PADDR[1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data; 0 when PSEL=0
- PREADY  out  1  tied 1 (zero wait states)
- PSLVERR  out  1  1 during the access phase to an unmapped address
- GPIO_IN  in  IO_NUM  asynchronous pin inputs
- GPIO_OUT  out  IO_NUM  output register
- GPIO_OE  out  IO_NUM  output-enable register
- INT  out  IO_NUM  registered per-channel interrupt (= INT_STAT)
- INT_OR  out  1  registered OR of INT_STAT

## Operation
- Register map (offset, access):
  - 0x00 IN (RO): debounced inputs.
  - 0x04 OUT (RW).
  - 0x08 OE (RW).
  - 0x0C INT_EN (RW).
  - 0x10 TYPE_LO (RW, 2 bits/channel, ch0–15).
  - 0x14 TYPE_HI (RW, ch16–31).
  - 0x18 INT_STAT (R/W1C).
  - 0x1C DEBOUNCE (RW, DEBOUNCE_W bits).
  - 0x20 OUT_SET (WO, reads 0): OUT |= PWDATA.
  - 0x24 OUT_CLR (WO, reads 0): OUT &= ~PWDATA.
- A write takes effect on the PCLK edge where PSEL&PENABLE&PWRITE. Unmapped writes are discarded, with PSLVERR=1. Unmapped reads return 0, with PSLVERR=1.
- Input path per channel: SYNC_STAGES flops give s. Debounced value d and counter cnt:
  - s==d: cnt<=0.
  - s!=d and cnt+1 >= max(DEBOUNCE,1): d<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - A glitch shorter than the threshold never reaches d.
- Event detection uses d versus d_prev (registered). Type codes:
  - 00: rising edge.
  - 01: falling edge.
  - 10: both edges.
  - 11: level-high (event every cycle d=1).
- INT_STAT[i] is set when an event occurs and INT_EN[i]=1. It is cleared by a write of 1 to INT_STAT. When set and clear happen in the same cycle, set wins. Clearing INT_EN does not clear INT_STAT.
- A level-high interrupt re-asserts the cycle after a clear while d remains 1.
- Changing DEBOUNCE mid-count applies immediately to the comparison; cnt is not reset.
- Reset values:
  - All registers, sync flops, d, d_prev and cnt are 0; DEBOUNCE = DEBOUNCE_RST.
  - Outputs: GPIO_OUT=0, GPIO_OE=0, INT=0, INT_OR=0, PSLVERR=0, PRDATA=0.
  - Reset asserted mid-transfer aborts the transfer; no register is written on that edge.

## Timing
- APB: zero-wait. PRDATA is combinational from registers during setup and access phases.
- Write-to-GPIO_OUT/OE latency: 1 cycle after the access edge.
- GPIO_IN change to IN bit change: SYNC_STAGES + max(DEBOUNCE,1) cycles, input held stable throughout.
- d change to INT_STAT/INT/INT_OR set: 2 cycles (d_prev compare registered, then status register).
- W1C to INT deassert: 1 cycle, unless an event occurs that same cycle.
- A read of INT_STAT in the same access as an event returns the pre-event value.

## Test plan
- Reset: assert PRESET for 2 cycles with GPIO_IN=all 1 → every output 0, DEBOUNCE reads DEBOUNCE_RST, and IN becomes 0xFF (IO_NUM=8) at cycle SYNC_STAGES+1 after reset release (DEBOUNCE=0).
- Register RW and atomics: write OUT=0xA5, OUT_SET=0x0A, OUT_CLR=0x81 → GPIO_OUT 0xA5, then 0xAF, then 0x2E. Read 0x20 → 0. Read 0x28 → PRDATA 0, PSLVERR 1.
- Debounce: DEBOUNCE=5; pulse GPIO_IN[0] high for 4 cycles → IN[0] stays 0. Hold it high for 5 cycles → IN[0]=1 exactly 2+5 cycles after the rise.
- Edge interrupts: INT_EN=0x07; TYPE_LO ch0=00, ch1=01, ch2=10; toggle each input 0→1→0 → INT[0] sets on the rise only, INT[1] on the fall only, INT[2] on both. INT_OR follows. W1C 0x07 clears all.
- Level and collision: ch3 type 11, enabled, input held 1 → W1C INT_STAT bit3 and INT[3] reads 1 again the next cycle. A W1C coinciding with a ch0 rising event leaves INT[0]=1.
- Mid-transfer reset: assert PRESET during the access phase of a write OUT=0xFF → GPIO_OUT remains 0.
